// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command decoder and single-port byte memory behind an SPI slave.
// Each received 10-bit word carries a 2-bit command in din[9:8] and an
// address or data byte in din[7:0]. Write and read pointers are kept
// independently. Read data goes back to the slave through registered
// dout/tx_valid outputs.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter bit AUTO_INC  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = ADDR_SIZE'(1);

    cmd_e                 cmd;
    logic [ADDR_SIZE-1:0] addr_field;
    logic [7:0]           data_field;

    logic [7:0]           mem [MEM_DEPTH];

    logic [ADDR_SIZE-1:0] wr_addr, wr_addr_next;
    logic [ADDR_SIZE-1:0] rd_addr, rd_addr_next;
    logic [7:0]           dout_next;
    logic                 tx_valid_next;
    logic                 mem_we;

    // Split the received word into command, address and data fields.
    // The address field keeps only the low ADDR_SIZE bits, so the unused
    // upper bits of din[7:0] play no part in address commands.
    always_comb begin
        cmd        = cmd_e'(din[9:8]);
        addr_field = din[ADDR_SIZE-1:0];
        data_field = din[7:0];
    end

    // Work out the next pointers and outputs from the accepted command.
    // The pointers have ADDR_SIZE bits, so an increment wraps modulo MEM_DEPTH.
    always_comb begin
        // NOTE: every signal gets a hold value before the case, so no path
        // leaves a signal unassigned and no latch is inferred.
        wr_addr_next  = wr_addr;
        rd_addr_next  = rd_addr;
        dout_next     = dout;
        tx_valid_next = tx_valid;
        mem_we        = 1'b0;

        if (rx_valid) begin
            // Any accepted command clears tx_valid. Only a read-data
            // command sets it again.
            tx_valid_next = 1'b0;
            unique case (cmd)
                CMD_WR_ADDR: wr_addr_next = addr_field;
                CMD_WR_DATA: begin
                    mem_we = rst_n;
                    if (AUTO_INC) begin
                        wr_addr_next = wr_addr + ADDR_ONE;
                    end
                end
                CMD_RD_ADDR: rd_addr_next = addr_field;
                CMD_RD_DATA: begin
                    dout_next     = mem[rd_addr];
                    tx_valid_next = 1'b1;
                    if (AUTO_INC) begin
                        rd_addr_next = rd_addr + ADDR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pointer and output registers. The reset is synchronous and takes
    // priority over any command arriving in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples values from before the edge.
        if (!rst_n) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            dout     <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            wr_addr  <= wr_addr_next;
            rd_addr  <= rd_addr_next;
            dout     <= dout_next;
            tx_valid <= tx_valid_next;
        end
    end

    // Memory write port. mem_we is low while reset is asserted, so commands
    // that arrive during reset are ignored.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset. Contents survive rst_n and stay
        // undefined until written, which lets the array map onto RAM.
        if (mem_we) begin
            mem[wr_addr] <= data_field;
        end
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Downstream consumer of the SPI slave's 10-bit receive word (rx_data/rx_valid) and producer of its transmit byte (tx_data/tx_valid).
- Decodes the 2-bit command in din[9:8] and maintains independent write and read address pointers.
- Performs single-port memory writes and reads.
- Returns read data to the SPI slave for shifting out on MISO.

Parameters:
- MEM_DEPTH, 256, number of 8-bit memory words; must equal 2**ADDR_SIZE.
- ADDR_SIZE, 8, address pointer width; legal range 1..8.
- AUTO_INC, 0, when 1, each write-data command post-increments wr_addr and each read-data command post-increments rd_addr.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- din  input  10  command word from SPI slave (its rx_data).
- rx_valid  input  1  din qualifier; single-cycle pulse per received word.
- dout  output  8  read data to SPI slave (its tx_data).
- tx_valid  output  1  dout qualifier to SPI slave.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - wr_addr=0, rd_addr=0, dout=8'h00, tx_valid=0.
  - Memory array is not cleared; contents are undefined until written.
  - rx_valid is ignored while rst_n=0. Reset takes priority over any command in the same cycle.
- Commands are accepted only when rx_valid=1 at a rising edge. din is don't-care when rx_valid=0, and all state holds.
- Command decode, on cmd=din[9:8]; a=din[ADDR_SIZE-1:0]; d=din[7:0]:
  - 2'b00 write-address: wr_addr<=a.
  - 2'b01 write-data: mem[wr_addr]<=d. If AUTO_INC: wr_addr<=wr_addr+1 modulo MEM_DEPTH (0xFF wraps to 0x00).
  - 2'b10 read-address: rd_addr<=a.
  - 2'b11 read-data: dout<=mem[rd_addr]; tx_valid<=1. If AUTO_INC: rd_addr<=rd_addr+1 modulo MEM_DEPTH. din[7:0] is ignored (dummy byte).
- Latency:
  - Write-data updates memory at the accepting edge.
  - Read-data presents dout and tx_valid=1 in the cycle after the accepting edge (1-cycle latency).
- tx_valid protocol:
  - Once set, tx_valid and dout hold until the next accepted command.
  - Any accepted command other than 2'b11 clears tx_valid at that edge; dout holds its last value.
  - A back-to-back 2'b11 re-asserts tx_valid with fresh data, with no dead cycle.
- Pointer independence: wr_addr and rd_addr are separate registers. A 2'b00 command never moves rd_addr; a 2'b10 command never moves wr_addr.
- Read-after-write to the same address, on any later accepted read-data, returns the newly written byte. Same-cycle conflicts are impossible: at most one command per cycle.
- If ADDR_SIZE<8, upper bits of din[7:0] are ignored for address commands.
- Reset mid-sequence, e.g. between a 2'b10 and a 2'b11:
  - Pointers return to 0.
  - A subsequent 2'b11 reads mem[0].
  - Previously written memory data is retained.
- No output is combinational from inputs; dout and tx_valid are registered.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with rx_valid=1, din=10'h3FF. Required: dout=0x00, tx_valid=0 throughout and for the first cycle after release.
- Write then read: din=10'h012 (wr_addr=0x12), then 10'h1A5 (mem[0x12]=0xA5), then 10'h212 (rd_addr=0x12), then 10'h300. Required: dout=0xA5, tx_valid=1 one cycle after the 0x300 edge; tx_valid stays 1 while rx_valid=0.
- tx_valid clear: after the previous step, send din=10'h055. Required: tx_valid=0 next cycle, dout still 0xA5; then send 10'h200 followed by a read-data command and confirm mem[0] is read.
- Pointer independence: write 0x3C at 0x40, then issue 10'h040 again followed by 10'h2xx with rd_addr=0x10 previously written 0x77. Required: a read-data returns 0x77, not 0x3C.
- AUTO_INC=1 wrap: wr_addr=0xFF, write-data 0x11 then 0x22; rd_addr=0xFF, two back-to-back 2'b11 commands. Required: dout=0x11 then 0x22, tx_valid continuously 1, and mem[0x00]=0x22.
- Reset mid-operation: set rd_addr=0x12, pulse rst_n=0 for one cycle, then send 10'h300. Required: dout=mem[0x00] (its last written value), mem[0x12] still 0xA5 on a later read.
